// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer:
// reconfig register map, counter word packing and FSM states.
package pll_cfg_pkg;

   localparam logic [5:0] ADDR_MODE   = 6'h00;
   localparam logic [5:0] ADDR_STATUS = 6'h01;
   localparam logic [5:0] ADDR_START  = 6'h02;
   localparam logic [5:0] ADDR_N      = 6'h03;
   localparam logic [5:0] ADDR_M      = 6'h04;
   localparam logic [5:0] ADDR_C      = 6'h05;
   localparam logic [5:0] ADDR_K      = 6'h07;
   localparam logic [5:0] ADDR_BW     = 6'h08;

   typedef enum logic [2:0] {
      IDLE,
      WR_MODE,
      WR_TABLE,
      WR_START,
      WAIT_LOCK
   } state_t;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } cfg_wr_t;

   function automatic logic [31:0] cnt_word(
      input logic [7:0] hi,
      input logic [7:0] lo,
      input logic       bypass,
      input logic       odd,
      input logic [4:0] c_sel
   );
      return {9'd0, c_sel, odd, bypass, hi, lo};
   endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM write-only link from the sequencer to the
// altera_pll_reconfig management slave.
interface pll_reconfig_seq_if;

   logic [5:0]  address;
   logic [31:0] writedata;
   logic        write;
   logic        waitrequest;

   modport master (
      output address,
      output writedata,
      output write,
      input  waitrequest
   );

   modport slave (
      input  address,
      input  writedata,
      input  write,
      output waitrequest
   );

endinterface

// File: rtl/pll_cfg_rom.sv
// Clock profile ROM: {addr,data} for each (mode, idx) write.
// Mode 0 is PAL; any other mode index returns the NTSC profile.
module pll_cfg_rom
   import pll_cfg_pkg::*;
(
   input  logic [1:0] mode,
   input  logic [2:0] idx,
   output cfg_wr_t    wr
);

   logic ntsc;

   assign ntsc = (mode != 2'd0);

   always_comb begin
      wr = '{addr: ADDR_BW, data: 32'h0000_0006};
      case (idx)
         3'd0: wr = '{addr: ADDR_N,
                      data: cnt_word(8'd0, 8'd0, 1'b1, 1'b0, 5'd0)};
         3'd1: wr = '{addr: ADDR_M,
                      data: ntsc ? cnt_word(8'd5, 8'd5, 1'b0, 1'b0, 5'd0)
                                 : cnt_word(8'd4, 8'd4, 1'b0, 1'b0, 5'd0)};
         3'd2: wr = '{addr: ADDR_C,
                      data: ntsc ? cnt_word(8'd4, 8'd4, 1'b0, 1'b0, 5'd0)
                                 : cnt_word(8'd4, 8'd3, 1'b0, 1'b1, 5'd0)};
         3'd3: wr = '{addr: ADDR_C,
                      data: ntsc ? cnt_word(8'd8, 8'd8, 1'b0, 1'b0, 5'd1)
                                 : cnt_word(8'd7, 8'd7, 1'b0, 1'b0, 5'd1)};
         3'd4: wr = '{addr: ADDR_K,
                      data: ntsc ? 32'h3D70_A3D7 : 32'hD3EC_811D};
         default: ;
      endcase
   end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Replays a clock profile into the PLL reconfig IP, fires START
// and waits for relock (or times out) in the mgmt clock domain.
module pll_reconfig_seq
   import pll_cfg_pkg::*;
#(
   parameter int NUM_MODES    = 2,
   parameter int WR_PER_MODE  = 6,
   parameter int LOCK_TIMEOUT = 1000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req,
   input  logic [1:0]         mode_sel,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [1:0]         cur_mode,
   input  logic               pll_locked,
   pll_reconfig_seq_if.master mgmt
);

   localparam int TW = $clog2(LOCK_TIMEOUT);
   localparam logic [TW-1:0] TMR_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] TMR_MAX  = '1;
   localparam logic [TW-1:0] LOCK_MIN = TW'(16);
   localparam logic [2:0]    NM       = 3'(NUM_MODES);
   localparam logic [2:0]    IDX_LAST = 3'(WR_PER_MODE - 1);

   state_t        state, nstate;
   logic          lock_m, lock_s;
   logic [1:0]    mode_q;
   logic [2:0]    idx;
   logic [TW-1:0] tmr;
   logic          pend_v;
   logic [1:0]    pend_m;
   cfg_wr_t       rom_wr;

   logic          wr_done;
   logic          launch;
   logic [1:0]    launch_m;
   logic          launch_ok;
   logic          lock_ok;
   logic          tmo;

   pll_cfg_rom u_rom (
      .mode (mode_q),
      .idx  (idx),
      .wr   (rom_wr)
   );

   assign wr_done   = mgmt.write & ~mgmt.waitrequest;
   // A parked request always wins over a fresh one in IDLE.
   assign launch    = pend_v | req;
   assign launch_m  = pend_v ? pend_m : mode_sel;
   assign launch_ok = launch && ({1'b0, launch_m} < NM);
   // The first 16 cycles can still see the pre-START lock level.
   assign lock_ok   = lock_s && (tmr >= LOCK_MIN);
   assign tmo       = (tmr == TMR_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE:      if (launch_ok) nstate = WR_MODE;
         WR_MODE:   if (wr_done) nstate = WR_TABLE;
         WR_TABLE:  if (wr_done && idx == IDX_LAST) nstate = WR_START;
         WR_START:  if (wr_done) nstate = WAIT_LOCK;
         WAIT_LOCK: if (lock_ok || tmo) nstate = IDLE;
         default:   nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_m   <= 1'b0;
         lock_s   <= 1'b0;
         mode_q   <= 2'd0;
         idx      <= 3'd0;
         tmr      <= '0;
         pend_v   <= 1'b0;
         pend_m   <= 2'd0;
         done     <= 1'b0;
         error    <= 1'b0;
         cur_mode <= 2'd0;
      end else begin
         lock_m <= pll_locked;
         lock_s <= lock_m;
         done   <= 1'b0;
         if (req && (state != IDLE || pend_v)) begin
            pend_v <= 1'b1;
            pend_m <= mode_sel;
         end else if (state == IDLE) begin
            pend_v <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (launch) begin
                  mode_q <= launch_m;
                  error  <= ~launch_ok;
               end
            end
            WR_MODE:  idx <= 3'd0;
            WR_TABLE: if (wr_done) idx <= idx + 3'd1;
            WR_START: tmr <= '0;
            WAIT_LOCK: begin
               if (tmr != TMR_MAX) tmr <= tmr + TW'(1);
               if (lock_ok) begin
                  cur_mode <= mode_q;
                  done     <= 1'b1;
               end else if (tmo) begin
                  error <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy           = (state != IDLE);
      mgmt.write     = 1'b0;
      mgmt.address   = 6'd0;
      mgmt.writedata = 32'd0;
      unique case (state)
         WR_MODE: begin
            mgmt.write   = 1'b1;
            mgmt.address = ADDR_MODE;
         end
         WR_TABLE: begin
            mgmt.write     = 1'b1;
            mgmt.address   = rom_wr.addr;
            mgmt.writedata = rom_wr.data;
         end
         WR_START: begin
            mgmt.write   = 1'b1;
            mgmt.address = ADDR_START;
         end
         default: ;
      endcase
      // Reset abandons a stalled write without waiting for the slave.
      if (!rst_n) mgmt.write = 1'b0;
   end

endmodule
